// File: rtl/psddivide_sched.sv
// rtl/psddivide_sched.sv - round-robin scheduler and sequencer for a shared sequential divider
module psddivide_sched #(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_dividend,
   input  logic [31:0] req0_divisor,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_dividend,
   input  logic [31:0] req1_divisor,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_quotient,
   output logic [31:0] rsp_rest,
   output logic        rsp_dbz,
   output logic        busy,
   output logic        div_start,
   output logic        div_stop,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic [31:0] div_quotient,
   input  logic [31:0] div_rest
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      RUN   = 3'd2,
      STOP  = 3'd3,
      CAPT  = 3'd4,
      RESP  = 3'd5
   } state_t;

   // Last RUN cycle index: the counter runs 0..CNT_LAST, i.e. DIV_CYCLES cycles.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   // Requester favoured when both are valid; flips away from whoever was just granted.
   logic             rr_favour;
   logic             accept;
   logic             grant_id;
   logic [31:0]      grant_dividend;
   logic [31:0]      grant_divisor;
   logic             grant_dbz;

   // Arbitration: only in IDLE, single valid wins outright, ties go to the favoured side.
   always_comb begin
      accept   = 1'b0;
      grant_id = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && req1_valid) begin
            accept   = 1'b1;
            grant_id = rr_favour;
         end else if (req0_valid) begin
            accept   = 1'b1;
            grant_id = 1'b0;
         end else if (req1_valid) begin
            accept   = 1'b1;
            grant_id = 1'b1;
         end
      end
   end

   assign req0_ready     = accept && !grant_id;
   assign req1_ready     = accept && grant_id;
   assign grant_dividend = grant_id ? req1_dividend : req0_dividend;
   assign grant_divisor  = grant_id ? req1_divisor  : req0_divisor;
   assign grant_dbz      = (grant_divisor == 32'd0);

   // State register; reset abandons any division in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and strobe/status decode.
   always_comb begin
      state_next = state;
      div_start  = 1'b0;
      div_stop   = 1'b0;
      rsp_valid  = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = grant_dbz ? RESP : START;
            end
         end
         START: begin
            div_start  = 1'b1;
            state_next = RUN;
         end
         RUN: begin
            if (count == CNT_LAST) begin
               state_next = STOP;
            end
         end
         STOP: begin
            div_stop   = 1'b1;
            state_next = CAPT;
         end
         CAPT: begin
            state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Iteration counter: cleared on the start cycle, saturates at the last RUN index.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (state == START) begin
         count <= '0;
      end else if (state == RUN && count != CNT_LAST) begin
         count <= count + 1'b1;
      end
   end

   // Operand hold, requester tagging and round-robin update at accept.
   always_ff @(posedge clock) begin
      if (reset) begin
         div_dividend <= '0;
         div_divisor  <= '0;
         rsp_id       <= 1'b0;
         rr_favour    <= 1'b0;
      end else if (accept) begin
         div_dividend <= grant_dividend;
         div_divisor  <= grant_divisor;
         rsp_id       <= grant_id;
         rr_favour    <= ~grant_id;
      end
   end

   // Result registers: divide-by-zero resolved at accept, normal results taken in CAPT.
   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_quotient <= '0;
         rsp_rest     <= '0;
         rsp_dbz      <= 1'b0;
      end else if (accept && grant_dbz) begin
         rsp_quotient <= 32'hFFFF_FFFF;
         rsp_rest     <= grant_dividend;
         rsp_dbz      <= 1'b1;
      end else if (state == CAPT) begin
         rsp_quotient <= div_quotient;
         rsp_rest     <= div_rest;
         rsp_dbz      <= 1'b0;
      end
   end

endmodule
